// File: rtl/pool2x2_stream.sv
// Streaming 2x2 stride-2 pooling stage, max or average per frame.
// Windows are formed on the fly from raster pixels via a half-row line buffer.
`timescale 1ns/1ps
module pool2x2_stream #(
    parameter int DATA_W = 32,
    parameter int CH     = 32,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24,
    parameter int SIGNED = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 valid_in,
    input  logic                 sof_in,
    input  logic [CH*DATA_W-1:0] data_in,
    output logic                 valid_out,
    output logic [CH*DATA_W-1:0] data_out,
    output logic                 eof_out,
    output logic                 err_out
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LD = IMG_W / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;
    localparam int PW = DATA_W + 1;
    localparam bit SG = (SIGNED != 0);

    logic [CW-1:0]        col_q;
    logic [RW-1:0]        row_q;
    logic                 mode_q;
    logic [CH*DATA_W-1:0] h_q;
    logic [CH*PW-1:0]     lb [LD];

    logic [CW-1:0]        col_e;
    logic [RW-1:0]        row_e;
    logic                 mode_e;
    logic                 at_org;
    logic                 last_col;
    logic                 last_row;
    logic                 fire;
    logic                 err;
    logic [LW-1:0]        idx;
    logic [CH*PW-1:0]     pair_all;
    logic [CH*DATA_W-1:0] res_all;

    // Effective position/mode of this beat: sof forces pixel (0,0) and a fresh mode
    always_comb begin
        at_org   = (col_q == '0) && (row_q == '0);
        col_e    = sof_in ? '0 : col_q;
        row_e    = sof_in ? '0 : row_q;
        mode_e   = sof_in ? mode : mode_q;
        last_col = (col_e == CW'(IMG_W - 1));
        last_row = (row_e == RW'(IMG_H - 1));
        fire     = valid_in && col_e[0] && row_e[0];
        err      = valid_in && sof_in && !at_org;
        idx      = LW'(col_e >> 1);
    end

    genvar g;
    for (g = 0; g < CH; g++) begin : g_ch
        logic [DATA_W-1:0] hv;
        logic [DATA_W-1:0] pv;
        logic [PW-1:0]     lv;
        logic [PW-1:0]     hx;
        logic [PW-1:0]     px;
        logic [PW-1:0]     pair;
        logic [PW:0]       lx;
        logic [PW:0]       qx;
        logic [PW:0]       sum;
        logic              hgt;
        logic              lgt;
        logic [DATA_W-1:0] res;

        assign hv = h_q[g*DATA_W +: DATA_W];
        assign pv = data_in[g*DATA_W +: DATA_W];
        assign lv = lb[idx][g*PW +: PW];

        // Horizontal pair, then vertical combine against the buffered pair
        always_comb begin
            hx   = {SG & hv[DATA_W-1], hv};
            px   = {SG & pv[DATA_W-1], pv};
            hgt  = $signed(hx) > $signed(px);
            pair = mode_e ? (hx + px) : (hgt ? hx : px);
            lx   = {SG & lv[PW-1], lv};
            qx   = {SG & pair[PW-1], pair};
            lgt  = $signed(lx) > $signed(qx);
            sum  = lx + qx;
            if (mode_e) begin
                res = SG ? DATA_W'($signed(sum) >>> 2)
                         : DATA_W'(sum >> 2);
            end else begin
                res = DATA_W'(lgt ? lx : qx);
            end
        end

        assign pair_all[g*PW +: PW]       = pair;
        assign res_all[g*DATA_W +: DATA_W] = res;
    end

    // Raster counters, frame mode and even-column hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= 1'b0;
            h_q    <= '0;
        end else if (valid_in) begin
            mode_q <= mode_e;
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_e + RW'(1);
            end else begin
                col_q <= col_e + CW'(1);
                row_q <= row_e;
            end
            if (!col_e[0]) begin
                h_q <= data_in;
            end
        end
    end

    // Line buffer holds the even-row horizontal pairs; contents need no reset
    always_ff @(posedge clk) begin
        if (valid_in && col_e[0] && !row_e[0]) begin
            lb[idx] <= pair_all;
        end
    end

    // Registered outputs: one-cycle pulses, data held between windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            eof_out   <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            valid_out <= fire;
            eof_out   <= fire && last_col && last_row;
            err_out   <= err;
            if (fire) begin
                data_out <= res_all;
            end
        end
    end

endmodule
